// File: rtl/axil_pkg.sv
// Shared response codes and FSM state types for the AXI-Lite
// default (decode-error) slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACK,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axil_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module axil_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_default_slave.sv
// Default slave: terminates unmapped AXI-Lite accesses with an error
// response and keeps debug counters / last-error address.
module axil_default_slave
  import axil_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [1:0]                RESP_CODE      = RESP_DECERR,
  parameter logic [AXI_DATA_WIDTH-1:0] RDATA_FILL     = '0,
  parameter int                        CNT_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      slv_invalid_wr,
  input  logic                      slv_invalid_rd,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [CNT_WIDTH-1:0]      err_wr_cnt,
  output logic [CNT_WIDTH-1:0]      err_rd_cnt,
  output logic [AXI_ADDR_WIDTH-1:0] last_err_addr,
  output logic                      last_err_wr,
  output logic                      err_irq
);

  wr_state_t wr_state_q, wr_state_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic awready_q, awready_d;
  logic wready_q, wready_d;
  logic bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;

  rd_state_t rd_state_q, rd_state_d;
  logic arready_q, arready_d;
  logic rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  logic [AXI_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic last_wr_q, last_wr_d;
  logic irq_q, irq_d;

  logic aw_hs, w_hs, b_hs, ar_acc, r_hs;

  assign aw_hs  = awready_q && s_axil_awvalid;
  assign w_hs   = wready_q && s_axil_wvalid;
  assign b_hs   = bvalid_q && s_axil_bready;
  assign ar_acc = (rd_state_q == R_ACK);
  assign r_hs   = rvalid_q && s_axil_rready;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      W_IDLE: begin
        awready_d = s_axil_awvalid && slv_invalid_wr
                    && !aw_done_q && !awready_q;
        wready_d  = s_axil_wvalid && slv_invalid_wr
                    && !w_done_q && !wready_q;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_q && w_done_q) begin
          wr_state_d = W_RESP;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_CODE;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
    endcase
  end

  // R_ACK assumes arvalid is held, so acceptance is unconditional there
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s_axil_arvalid && slv_invalid_rd) begin
          arready_d  = 1'b1;
          rd_state_d = R_ACK;
        end
      end
      R_ACK: begin
        rvalid_d   = 1'b1;
        rdata_d    = RDATA_FILL;
        rresp_d    = RESP_CODE;
        rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (r_hs) begin
          rvalid_d   = 1'b0;
          rdata_d    = '0;
          rresp_d    = RESP_OKAY;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write acceptance wins a same-edge tie with a read
  always_comb begin
    last_addr_d = last_addr_q;
    last_wr_d   = last_wr_q;
    if (aw_hs) begin
      last_addr_d = s_axil_awaddr;
      last_wr_d   = 1'b1;
    end else if (ar_acc) begin
      last_addr_d = s_axil_araddr;
      last_wr_d   = 1'b0;
    end
    irq_d = aw_hs || ar_acc;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q  <= W_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rd_state_q  <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      last_addr_q <= '0;
      last_wr_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rd_state_q  <= rd_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      last_addr_q <= last_addr_d;
      last_wr_q   <= last_wr_d;
      irq_q       <= irq_d;
    end
  end

  axil_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_wr_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (b_hs),
    .cnt     (err_wr_cnt)
  );

  axil_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_rd_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (r_hs),
    .cnt     (err_rd_cnt)
  );

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign last_err_addr  = last_addr_q;
  assign last_err_wr    = last_wr_q;
  assign err_irq        = irq_q;

endmodule

// File: tb/tb_axil_default_slave.sv
// Bench for axil_default_slave: default and narrow-counter/SLVERR
// instances share stimulus and are checked against one model.
module tb_axil_default_slave;

  localparam logic [31:0] ALT_FILL = 32'hDEAD_BEEF;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic inv_wr = 1'b0, inv_rd = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic arvalid = 1'b0, rready = 1'b0;

  logic d_awready, d_wready, d_bvalid, d_arready, d_rvalid;
  logic d_last_wr, d_irq;
  logic [1:0] d_bresp, d_rresp;
  logic [31:0] d_rdata, d_last_addr;
  logic [15:0] d_wcnt, d_rcnt;

  logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic a_last_wr, a_irq;
  logic [1:0] a_bresp, a_rresp;
  logic [31:0] a_rdata, a_last_addr;
  logic [1:0] a_wcnt, a_rcnt;

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;

  always #5 aclk = ~aclk;

  axil_default_slave u_dut (
    .aclk (aclk), .aresetn (aresetn),
    .slv_invalid_wr (inv_wr), .slv_invalid_rd (inv_rd),
    .s_axil_awaddr (awaddr), .s_axil_awvalid (awvalid),
    .s_axil_awready (d_awready),
    .s_axil_wvalid (wvalid), .s_axil_wready (d_wready),
    .s_axil_bresp (d_bresp), .s_axil_bvalid (d_bvalid),
    .s_axil_bready (bready),
    .s_axil_araddr (araddr), .s_axil_arvalid (arvalid),
    .s_axil_arready (d_arready),
    .s_axil_rdata (d_rdata), .s_axil_rresp (d_rresp),
    .s_axil_rvalid (d_rvalid), .s_axil_rready (rready),
    .err_wr_cnt (d_wcnt), .err_rd_cnt (d_rcnt),
    .last_err_addr (d_last_addr), .last_err_wr (d_last_wr),
    .err_irq (d_irq)
  );

  axil_default_slave #(
    .RESP_CODE (2'b10), .RDATA_FILL (ALT_FILL), .CNT_WIDTH (2)
  ) u_alt (
    .aclk (aclk), .aresetn (aresetn),
    .slv_invalid_wr (inv_wr), .slv_invalid_rd (inv_rd),
    .s_axil_awaddr (awaddr), .s_axil_awvalid (awvalid),
    .s_axil_awready (a_awready),
    .s_axil_wvalid (wvalid), .s_axil_wready (a_wready),
    .s_axil_bresp (a_bresp), .s_axil_bvalid (a_bvalid),
    .s_axil_bready (bready),
    .s_axil_araddr (araddr), .s_axil_arvalid (arvalid),
    .s_axil_arready (a_arready),
    .s_axil_rdata (a_rdata), .s_axil_rresp (a_rresp),
    .s_axil_rvalid (a_rvalid), .s_axil_rready (rready),
    .err_wr_cnt (a_wcnt), .err_rd_cnt (a_rcnt),
    .last_err_addr (a_last_addr), .last_err_wr (a_last_wr),
    .err_irq (a_irq)
  );

  // Model: the write side is "responding" while bvalid is up, the read
  // side is idle when neither arready nor rvalid is up.
  // Counts are unbounded and clipped per instance at compare time.
  bit m_awready, m_wready, m_aw_got, m_w_got, m_bvalid;
  bit m_arready, m_rvalid, m_last_wr, m_irq;
  logic [31:0] m_last_addr;
  int m_wcnt, m_rcnt;

  wire mh_aw = m_awready && awvalid;
  wire mh_w  = m_wready && wvalid;
  wire mh_b  = m_bvalid && bready;
  wire mh_ar = m_arready;
  wire mh_r  = m_rvalid && rready;

  initial forever begin
    @(posedge aclk);
    if (!aresetn) begin
      m_awready <= 0; m_wready <= 0; m_aw_got <= 0; m_w_got <= 0;
      m_bvalid <= 0; m_arready <= 0; m_rvalid <= 0;
      m_last_wr <= 0; m_irq <= 0; m_last_addr <= '0;
      m_wcnt <= 0; m_rcnt <= 0;
    end else begin
      m_irq <= mh_aw || mh_ar;
      if (mh_aw) begin
        m_last_addr <= awaddr; m_last_wr <= 1;
      end else if (mh_ar) begin
        m_last_addr <= araddr; m_last_wr <= 0;
      end
      m_awready <= !m_bvalid && !m_aw_got && !m_awready
                   && awvalid && inv_wr;
      m_wready  <= !m_bvalid && !m_w_got && !m_wready
                   && wvalid && inv_wr;
      if (mh_b) begin
        m_bvalid <= 0; m_wcnt <= m_wcnt + 1;
        m_aw_got <= 0; m_w_got <= 0;
      end else begin
        m_bvalid <= m_bvalid || (m_aw_got && m_w_got);
        m_aw_got <= m_aw_got || mh_aw;
        m_w_got  <= m_w_got || mh_w;
      end
      m_arready <= !m_arready && !m_rvalid && arvalid && inv_rd;
      if (mh_ar) m_rvalid <= 1;
      else if (mh_r) begin
        m_rvalid <= 0; m_rcnt <= m_rcnt + 1;
      end
    end
  end

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  initial forever begin
    @(negedge aclk);
    if (chk_en) begin
      chk("awready", d_awready, m_awready);
      chk("wready", d_wready, m_wready);
      chk("bvalid", d_bvalid, m_bvalid);
      chk("bresp", d_bresp, m_bvalid ? 2'b11 : 2'b00);
      chk("arready", d_arready, m_arready);
      chk("rvalid", d_rvalid, m_rvalid);
      chk("rresp", d_rresp, m_rvalid ? 2'b11 : 2'b00);
      chk("rdata", d_rdata, 0);
      chk("wcnt", d_wcnt, sat(m_wcnt, 16));
      chk("rcnt", d_rcnt, sat(m_rcnt, 16));
      chk("last_addr", d_last_addr, m_last_addr);
      chk("last_wr", d_last_wr, m_last_wr);
      chk("irq", d_irq, m_irq);
      chk("alt_awready", a_awready, m_awready);
      chk("alt_wready", a_wready, m_wready);
      chk("alt_bvalid", a_bvalid, m_bvalid);
      chk("alt_bresp", a_bresp, m_bvalid ? 2'b10 : 2'b00);
      chk("alt_arready", a_arready, m_arready);
      chk("alt_rvalid", a_rvalid, m_rvalid);
      chk("alt_rresp", a_rresp, m_rvalid ? 2'b10 : 2'b00);
      chk("alt_rdata", a_rdata, m_rvalid ? ALT_FILL : 32'h0);
      chk("alt_wcnt", a_wcnt, sat(m_wcnt, 2));
      chk("alt_rcnt", a_rcnt, sat(m_rcnt, 2));
      chk("alt_last_addr", a_last_addr, m_last_addr);
      chk("alt_irq", a_irq, m_irq);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge aclk);
  endtask

  task automatic wait_ar();
    int n;
    n = 0;
    while (!d_arready && n < 16) begin
      tick();
      n++;
    end
    chk("ar_wait", d_arready, 1);
  endtask

  task automatic do_read(input logic [31:0] a);
    inv_rd = 1; rready = 1; araddr = a; arvalid = 1;
    wait_ar();
    tick();
    arvalid = 0;
    tick();
  endtask

  task automatic do_reset();
    awvalid = 0; wvalid = 0; arvalid = 0;
    aresetn = 0;
    tick(2);
    aresetn = 1;
  endtask

  int w_age, aw_dly, w_dly, r_age;
  bit w_act, r_act, hs_aw, hs_w, hs_ar, p_aw, p_w, p_ar;

  initial begin
    tick(3);
    aresetn = 1;
    chk_en = 1;
    chk("rst_bvalid", d_bvalid, 0);
    chk("rst_rvalid", d_rvalid, 0);
    chk("rst_wcnt", d_wcnt, 0);
    chk("rst_last_addr", d_last_addr, 0);

    // single error read
    rready = 1; inv_rd = 1; araddr = 32'h4000_0010; arvalid = 1;
    tick();
    chk("d1_arready", d_arready, 1);
    tick();
    arvalid = 0;
    chk("d1_arready_pulse", d_arready, 0);
    chk("d1_rvalid", d_rvalid, 1);
    chk("d1_rresp", d_rresp, 2'b11);
    chk("d1_rdata", d_rdata, 0);
    chk("d1_alt_rdata", a_rdata, ALT_FILL);
    chk("d1_last_addr", d_last_addr, 32'h4000_0010);
    chk("d1_last_wr", d_last_wr, 0);
    tick();
    chk("d1_rvalid_done", d_rvalid, 0);
    chk("d1_rcnt", d_rcnt, 1);

    // W three cycles ahead of AW, bready held low
    bready = 0; inv_wr = 1; wvalid = 1;
    tick();
    chk("d2_wready", d_wready, 1);
    chk("d2_awready_idle", d_awready, 0);
    tick();
    wvalid = 0;
    chk("d2_wready_pulse", d_wready, 0);
    tick();
    awaddr = 32'h8000_0000; awvalid = 1;
    tick();
    chk("d2_awready", d_awready, 1);
    tick();
    awvalid = 0;
    chk("d2_irq", d_irq, 1);
    chk("d2_last_addr", d_last_addr, 32'h8000_0000);
    chk("d2_last_wr", d_last_wr, 1);
    chk("d2_bvalid_early", d_bvalid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("d2_bvalid_hold", d_bvalid, 1);
      chk("d2_bresp_hold", d_bresp, 2'b11);
      chk("d2_alt_bresp", a_bresp, 2'b10);
      if (i < 4) tick();
    end
    bready = 1;
    tick();
    bready = 0;
    chk("d2_bvalid_done", d_bvalid, 0);
    chk("d2_bresp_done", d_bresp, 0);
    chk("d2_wcnt", d_wcnt, 1);

    // AW+W and AR accepted on the same edge
    do_reset();
    chk("d3_rst_rcnt", d_rcnt, 0);
    rready = 1; bready = 1; inv_wr = 1; inv_rd = 1;
    awaddr = 32'h20; araddr = 32'h10;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    chk("d3_awready", d_awready, 1);
    chk("d3_arready", d_arready, 1);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("d3_last_addr", d_last_addr, 32'h20);
    chk("d3_last_wr", d_last_wr, 1);
    chk("d3_irq", d_irq, 1);
    tick();
    chk("d3_irq_single", d_irq, 0);
    chk("d3_bvalid", d_bvalid, 1);
    chk("d3_rcnt", d_rcnt, 1);
    tick();
    chk("d3_wcnt", d_wcnt, 1);
    chk("d3_rcnt_hold", d_rcnt, 1);
    bready = 0;

    // saturation of the 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_read(32'h100 + 32'(k * 4));
      chk("d4_alt_rcnt", a_rcnt, (k < 3) ? k + 1 : 3);
      chk("d4_rcnt", d_rcnt, k + 1);
    end
    chk("d4_model_rcnt", m_rcnt, 5);

    // mapped read is never acknowledged
    rready = 1; inv_rd = 0; araddr = 32'h55; arvalid = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("d5_arready", d_arready, 0);
      chk("d5_rcnt", d_rcnt, 5);
    end
    arvalid = 0;

    // reset while a response is pending
    inv_rd = 1; rready = 0; araddr = 32'h77; arvalid = 1;
    wait_ar();
    tick();
    arvalid = 0;
    chk("d6_rvalid", d_rvalid, 1);
    chk("d6_alt_rresp", a_rresp, 2'b10);
    tick();
    chk("d6_rvalid_hold", d_rvalid, 1);
    aresetn = 0;
    tick();
    chk("d6_rvalid_rst", d_rvalid, 0);
    chk("d6_rresp_rst", d_rresp, 0);
    chk("d6_rcnt_rst", d_rcnt, 0);
    chk("d6_alt_rcnt_rst", a_rcnt, 0);
    aresetn = 1;
    do_read(32'h99);
    chk("d6_rcnt_after", d_rcnt, 1);
    chk("d6_last_addr", d_last_addr, 32'h99);

    // randomized traffic
    w_act = 0; r_act = 0; p_aw = 0; p_w = 0; p_ar = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      hs_aw = p_aw; hs_w = p_w; hs_ar = p_ar;
      if (i == 1500) begin
        aresetn = 0;
        awvalid = 0; wvalid = 0; arvalid = 0;
        w_act = 0; r_act = 0;
      end
      if (i == 1502) aresetn = 1;
      if (aresetn) begin
        bready = ($urandom % 3) != 0;
        rready = ($urandom % 3) != 0;
        if (hs_aw) awvalid = 0;
        if (hs_w) wvalid = 0;
        if (hs_ar) begin
          arvalid = 0; r_act = 0;
          if ($urandom % 2 == 0) inv_rd = 0;
        end
        if (w_act) begin
          w_age++;
          if (w_age == aw_dly) begin
            awvalid = 1; awaddr = $urandom;
          end
          if (w_age == w_dly) wvalid = 1;
          if (w_age > aw_dly && w_age > w_dly
              && !awvalid && !wvalid) begin
            w_act = 0;
            if ($urandom % 2 == 0) inv_wr = 0;
          end else if (!inv_wr && w_age > 12) begin
            awvalid = 0; wvalid = 0; w_act = 0;
          end
        end else if ($urandom % 4 == 0) begin
          w_act = 1; w_age = 0;
          aw_dly = $urandom_range(1, 4);
          w_dly = $urandom_range(1, 4);
          inv_wr = ($urandom % 4) != 0;
        end
        if (r_act) begin
          r_age++;
          if (!inv_rd && r_age > 10) begin
            arvalid = 0; r_act = 0;
          end
        end else if ($urandom % 3 == 0) begin
          r_act = 1; r_age = 0;
          arvalid = 1; araddr = $urandom;
          inv_rd = ($urandom % 4) != 0;
        end
      end
      p_aw = awvalid && d_awready;
      p_w  = wvalid && d_wready;
      p_ar = arvalid && d_arready;
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
